uart_rx: RTL
============

Name: uart_rx

Overview:
- UART receiver: the receive-side counterpart to the transmit baud tick path.
- Recovers 8N1 frames from the asynchronous serial input rx.
- Times bits with its own counter, which is re-phased to every start-bit falling edge. It does not use the free-running baud clock, so sampling stays centred on each bit.
- Presents the received byte with a one-cycle valid strobe and a framing-error flag to the CPU I/O port logic.

Parameters:
- CLKS_PER_BIT, 834, system clocks per bit period (834 = 2 x 417). Minimum legal value 4; must be even.
- CNT_W, $clog2(CLKS_PER_BIT), bit-counter width. Derived; never override.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- rx  input  1  serial line; idles high; asynchronous to clk.
- rx_data  output  8  last received byte; LSB received first.
- rx_valid  output  1  one-cycle pulse when rx_data/frame_err update.
- frame_err  output  1  stop bit sampled low on the last frame.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- One clock domain. reset_n is asynchronous assert, synchronous-safe deassert (already decided).
- Reset values:
  - rx_data = 0x00, rx_valid = 0, frame_err = 0, busy = 0.
  - Synchroniser flops = 1; state = IDLE; armed = 1; all counters = 0.
- Input synchroniser:
  - rx passes through 2 flops to give rx_s (2-cycle latency).
  - Only rx_s is used downstream.
- FSM states and transitions:
  - IDLE: if armed and rx_s == 0, go to START with cnt = 0. If rx_s == 1, set armed = 1.
  - START: cnt increments. At cnt == CLKS_PER_BIT/2 - 1, sample rx_s:
    - 0: go to DATA, cnt = 0, bit_idx = 0.
    - 1: glitch; go to IDLE with no strobe and no flag change.
  - DATA: at cnt == CLKS_PER_BIT - 1, shift rx_s into shreg MSB (right shift, LSB-first), cnt = 0, bit_idx++. After bit_idx 7 is sampled, go to STOP.
  - STOP: at cnt == CLKS_PER_BIT - 1 (mid stop bit):
    - rx_data <= shreg, frame_err <= ~rx_s, rx_valid = 1 for exactly one cycle.
    - Go to IDLE.
    - If rx_s == 0, armed = 0.
- Returning to IDLE at mid-stop lets the next start edge be caught even with a short stop bit.
- armed = 0 after a framing error, which blocks re-triggering during a held-low (break) line. Re-arm needs rx_s == 1 for at least one cycle.
- rx_valid asserts on every completed frame, including framing errors. frame_err qualifies it and holds until the next completed frame.
- No buffering: a new frame overwrites rx_data. The consumer must take the data in the rx_valid cycle or before the next frame's stop bit.
- Counter wrap: cnt is always cleared on a compare hit and never wraps naturally. cnt and bit_idx are cleared on every state entry.
- Reset mid-frame: immediate return to reset values; no rx_valid is produced for the partial frame.
- Latency: rx_valid fires 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT (+/-1) clocks after the rx falling edge.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1, with a PARITY state between DATA and STOP, one bit period long.
  - Adds output parity_err (1 bit, reset 0). It is set to (XOR of the 8 data bits) ^ sampled parity bit, and updates with rx_valid.
  - Latency grows by CLKS_PER_BIT.
- Undefined: no PARITY state and no parity_err port. Frame is 8N1 exactly as above.

Test Plan:
- All scenarios use CLKS_PER_BIT = 16.
- Reset: reset_n low with rx toggling -> all outputs 0, busy 0. After release with rx idle high, no rx_valid for 200 cycles.
- Byte 0xA5, 8N1, ideal timing: start edge -> rx_valid one cycle at 154 +/- 1 clocks, rx_data = 0xA5, frame_err = 0. Back-to-back 0x3C with a zero-gap stop bit -> second rx_valid, rx_data = 0x3C.
- Glitch: rx low for 5 cycles, then high -> busy high briefly, returns to IDLE, no rx_valid, rx_data unchanged.
- Framing error and break:
  - 0x55 with stop bit low -> rx_valid, rx_data = 0x55, frame_err = 1.
  - Hold rx low a further 100 cycles -> no further rx_valid.
  - rx high then 0x0F -> rx_data = 0x0F, frame_err = 0.
- Reset mid-frame: assert reset_n during bit 4 of 0xFF -> outputs at reset values. Next full 0x81 -> rx_data = 0x81.
- Timing margin: bit period stretched to 17 and compressed to 15 clocks for 0xC3 -> rx_data = 0xC3 both times, frame_err = 0. With UART_RX_PARITY_EN, 0xC3 with wrong parity -> parity_err = 1.

Source files
------------

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with start-edge re-phased bit timing
// Optional 8E1 parity check enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
    parameter int CLKS_PER_BIT = 834,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic [1:0]       sync_q, sync_d;
    state_t           state_q, state_d;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic             par_bit_q, par_bit_d;
    logic             parity_err_q, parity_err_d;
`endif

    logic rx_s;
    assign rx_s = sync_q[1];

    always_comb begin
        sync_d      = {sync_q[0], rx};
        state_d     = state_q;
        armed_d     = armed_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = frame_err_q;
`ifdef UART_RX_PARITY_EN
        par_bit_d    = par_bit_q;
        parity_err_d = parity_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                // A low line only starts a frame once it has been seen high since the last framing error.
                if (rx_s) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d   = S_START;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    shreg_d   = {rx_s, shreg_q[7:1]};
                    cnt_d     = '0;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d   = S_PARITY;
`else
                        state_d   = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == FULL_M1) begin
                    par_bit_d = rx_s;
                    cnt_d     = '0;
                    state_d   = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                // Leave at mid-stop so a short stop bit cannot hide the next start edge.
                if (cnt_q == FULL_M1) begin
                    rx_data_d   = shreg_q;
                    frame_err_d = ~rx_s;
                    rx_valid_d  = 1'b1;
                    armed_d     = rx_s;
                    cnt_d       = '0;
                    state_d     = S_IDLE;
`ifdef UART_RX_PARITY_EN
                    parity_err_d = (^shreg_q) ^ par_bit_q;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = S_IDLE;
                cnt_d     = '0;
                bit_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q      <= 2'b11;
            state_q     <= S_IDLE;
            armed_q     <= 1'b1;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            armed_q     <= armed_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= par_bit_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule
